modred_mont: RTL and testbench



---
 rtl/modred_pkg.sv | 26 ++
 rtl/modred_step.sv | 34 +++
 rtl/modred_mont.sv | 123 ++++++++++++
 tb/tb_modred_mont.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// modred_pkg: shared FSM state type and sizing helpers for the Montgomery reducer.
`default_nettype none

package modred_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RED  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    // Word size reduced per iteration: q = qH * 2^K + 1.
    function automatic int k_width(input int logq, input int logqh);
        return logq - logqh;
    endfunction

    function automatic int niter(input int logq, input int logqh);
        int k;
        k = logq - logqh;
        return (logq + k - 1) / k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/modred_step.sv
// modred_step: one combinational Montgomery word step, T -> (T + m*q) / 2^K with q = qH*2^K + 1.
`default_nettype none

module modred_step #(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 47
) (
    input  logic [2*LOGQ:0]  t_cur,
    input  logic [LOGQH-1:0] qh,
    output logic [2*LOGQ:0]  t_next
);

    localparam int K = LOGQ - LOGQH;
    localparam int W = 2 * LOGQ + 1;

    logic [K-1:0]    lo;
    logic [K-1:0]    m;
    logic            carry;
    logic [LOGQ-1:0] prod;

    // m*q = m*qH*2^K + m, and lo + m is either 0 (lo==0) or exactly 2^K,
    // so the low word collapses to a single carry into the shifted value.
    assign lo    = t_cur[K-1:0];
    assign m     = -lo;
    assign carry = |lo;
    assign prod  = {{LOGQH{1'b0}}, m} * {{K{1'b0}}, qh};

    assign t_next = (t_cur >> K)
                  + {{(W-LOGQ){1'b0}}, prod}
                  + {{(W-1){1'b0}}, carry};

endmodule

`default_nettype wire

// File: rtl/modred_mont.sv
// modred_mont: iterative Montgomery reducer, C = T * 2^(-K*NITER) mod q, fully reduced.
// Optional macro MODRED_CHECK_EN compiles in simulation-only assertions.
`default_nettype none

module modred_mont
    import modred_pkg::*;
#(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 47,
    parameter int NITER = niter(LOGQ, LOGQH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*LOGQ-1:0] T,
    input  logic [LOGQH-1:0]  qH,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGQ-1:0]   C
);

    localparam int K  = k_width(LOGQ, LOGQH);
    localparam int W  = 2 * LOGQ + 1;
    localparam int CW = $clog2(NITER + 1);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    t_reg;
    logic [W-1:0]    t_step;
    logic [LOGQH-1:0] qh_reg;
    logic [CW-1:0]   cnt;
    logic [LOGQ-1:0] q_full;
    logic            accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign q_full   = {qh_reg, {(K-1){1'b0}}, 1'b1};

    modred_step #(
        .LOGQ  (LOGQ),
        .LOGQH (LOGQH)
    ) u_step (
        .t_cur  (t_reg),
        .qh     (qh_reg),
        .t_next (t_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RED;
            RED:     if (cnt == CW'(NITER - 1)) state_nxt = CORR;
            CORR:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? RED : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg     <= '0;
            qh_reg    <= '0;
            cnt       <= '0;
            C         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                t_reg  <= {1'b0, T};
                qh_reg <= qH;
                cnt    <= '0;
            end else if (state == RED) begin
                t_reg <= t_step;
                cnt   <= cnt + CW'(1);
            end

            // After NITER steps t_reg < 2q, so one conditional subtract suffices.
            if (state == CORR) begin
                C         <= (t_reg >= {{(W-LOGQ){1'b0}}, q_full})
                           ? (t_reg[LOGQ-1:0] - q_full) : t_reg[LOGQ-1:0];
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MODRED_CHECK_EN
    logic [LOGQ-1:0]   q_in;
    logic [2*LOGQ-1:0] q_in_sq;

    assign q_in    = {qH, {(K-1){1'b0}}, 1'b1};
    assign q_in_sq = {{LOGQ{1'b0}}, q_in} * {{LOGQ{1'b0}}, q_in};

    if (K * NITER <= LOGQ) begin : g_niter_check
        $error("modred_mont: K*NITER must exceed LOGQ");
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (T < q_in_sq) else $error("modred_mont: T >= q^2 on accept");
            assert (qH != '0) else $error("modred_mont: qH == 0 on accept");
        end
        if (!rst && out_valid) begin
            assert (C < q_full) else $error("modred_mont: C >= q");
        end
    end

    a_c_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(C));
`endif

endmodule

`default_nettype wire

// File: tb/tb_modred_mont.sv
// tb_modred_mont: randomized scoreboard bench for modred_mont against a modular-halving reference.
`default_nettype none

module tb_modred_mont;

    localparam int LOGQ  = 64;
    localparam int LOGQH = 47;
    localparam int LAT   = 6;
    localparam logic [LOGQH-1:0] QH0 = 47'h400008C00000;
    localparam logic [LOGQ-1:0]  Q0  = 64'h8000118000000001;

    typedef struct {
        logic [LOGQ-1:0] c;
        logic [LOGQ-1:0] q;
        int              acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*LOGQ-1:0] t_in = '0;
    logic [LOGQH-1:0]  qh_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [LOGQ-1:0]   c_out;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_out_cyc = 0;
    int   prev_out_cyc = 0;
    bit   prev_ov = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    modred_mont #(.LOGQ(LOGQ), .LOGQH(LOGQH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .T         (t_in),
        .qH        (qh_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // C is the unique value with C*2^68 == T (mod q): reduce, then halve mod q 68 times.
    function automatic logic [LOGQ-1:0] model(input logic [127:0] t, input logic [LOGQ-1:0] q);
        logic [129:0] x;
        logic [129:0] qx;
        qx = {66'd0, q};
        x  = {2'b00, t} % qx;
        for (int i = 0; i < 68; i++) begin
            x = x[0] ? ((x + qx) >> 1) : (x >> 1);
        end
        return x[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] q_of(input logic [LOGQH-1:0] h);
        return {h, 16'd0, 1'b1};
    endfunction

    // Presents an operand from posedge+1 and returns at posedge+1 after its accept edge.
    task automatic present(input logic [127:0] t, input logic [LOGQH-1:0] h, output int waits);
        exp_t e;
        in_valid = 1'b1;
        t_in     = t;
        qh_in    = h;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                check(1'b0, "accept_timeout", 128'(waits), 128'd200);
                break;
            end
        end
        e.q   = q_of(h);
        e.c   = model(t, e.q);
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check(1'b0, "drain_timeout", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_out_valid", 128'(c_out), 128'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_ov) check((cyc - e.acc) == LAT, "latency", 128'(cyc - e.acc), 128'(LAT));
                    check(c_out == e.c, "C_value", 128'(c_out), 128'(e.c));
                    check(c_out < e.q, "C_below_q", 128'(c_out), 128'(e.q));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        prev_out_cyc = last_out_cyc;
                        last_out_cyc = cyc;
                    end
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [127:0] t;
        logic [127:0] qq;
        logic [LOGQ-1:0] q;
        logic [LOGQH-1:0] h;

        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "reset_out_valid", 128'(out_valid), 128'd0);
        check(c_out == '0, "reset_C", 128'(c_out), 128'd0);
        check(in_ready == 1'b1, "reset_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: zero, q, 2^68 mod q, q^2-1.
        out_ready = 1'b1;
        present(128'd0, QH0, w);
        drain();
        present({64'd0, Q0}, QH0, w);
        present((128'd1 << 68) % {64'd0, Q0}, QH0, w);
        qq = {64'd0, Q0} * {64'd0, Q0};
        present(qq - 128'd1, QH0, w);
        drain();
        check(model({64'd0, Q0}, Q0) == 64'd0, "model_q", 128'(model({64'd0, Q0}, Q0)), 128'd0);

        // Random operands and moduli with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            h  = {1'b1, 14'($urandom), $urandom};
            q  = q_of(h);
            qq = {64'd0, q} * {64'd0, q};
            t  = {$urandom, $urandom, $urandom, $urandom} % qq;
            present(t, h, w);
        end
        drain();
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;

        // Stall: hold out_ready low for 5 cycles with in_valid asserted.
        out_ready = 1'b0;
        present(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, QH0, w);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check(out_valid == 1'b1, "stall_out_valid_seen", 128'(out_valid), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        t_in     = 128'hDEAD_BEEF;
        qh_in    = QH0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(in_ready == 1'b0, "stall_in_ready", 128'(in_ready), 128'd0);
            check(out_valid == 1'b1, "stall_out_valid", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        present(128'h0000_0000_0000_0001_0000_0000_0000_0777, QH0, w);
        check(w == 0, "same_cycle_accept", 128'(w), 128'd0);
        drain();

        // Reset in RED with the counter at 2.
        present(128'h0F0F_0000_1234_5678_9ABC_DEF0_1357_9BDF, QH0, w);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "midreset_out_valid", 128'(out_valid), 128'd0);
        check(c_out == '0, "midreset_C", 128'(c_out), 128'd0);
        check(in_ready == 1'b1, "midreset_in_ready", 128'(in_ready), 128'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        present({64'd0, 64'h010000000000000A}, QH0, w);
        drain();

        // Back-to-back with out_ready high: results spaced exactly LAT cycles.
        present(128'h1111_2222_3333_4444_5555_6666_7777_8888 % qq, QH0, w);
        present(128'h0000_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF, QH0, w);
        drain();
        check((last_out_cyc - prev_out_cyc) == LAT, "b2b_spacing",
              128'(last_out_cyc - prev_out_cyc), 128'(LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
